// File: rtl/seq_shift_unit.sv
// Multi-mode sequential shifter: loads a W-bit operand and shifts it one bit per
// enabled falling clock edge. Define SEQ_SHIFT_OVF_EN to add the sticky ovf output.
module seq_shift_unit #(
  parameter int W     = 8,
  parameter int AMT_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [W-1:0]     in,
  input  logic             load,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  output logic [W-1:0]     o,
  output logic             busy,
  output logic             done,
  output logic             carry,
`ifdef SEQ_SHIFT_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state
);

  // Handshake: start is accepted only on an enabled edge in IDLE with load low;
  // done is a one-enabled-cycle pulse and busy covers the SHIFT state only.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] M_LOG = 2'b00;
  localparam logic [1:0] M_ARI = 2'b01;
  localparam logic [1:0] M_ROT = 2'b10;
  localparam logic [1:0] M_SER = 2'b11;

  state_t           state, state_n;
  logic [AMT_W-1:0] cnt, cnt_n;
  logic [W-1:0]     data, data_n;
  logic             carry_q, carry_n;
  logic             dir_q, dir_n;
  logic [1:0]       mode_q, mode_n;
  logic [W-1:0]     step;
  logic             step_out;
`ifdef SEQ_SHIFT_OVF_EN
  logic             ovf_q, ovf_n;
`endif

  // Single-bit step of the current storage using the mode/direction latched at start.
  always_comb begin
    step     = data;
    step_out = 1'b0;
    if (!dir_q) begin
      step_out = data[W-1];
      case (mode_q)
        M_ROT:   step = {data[W-2:0], data[W-1]};
        M_SER:   step = {data[W-2:0], ser_in};
        default: step = {data[W-2:0], 1'b0};
      endcase
    end else begin
      step_out = data[0];
      case (mode_q)
        M_LOG:   step = {1'b0, data[W-1:1]};
        M_ARI:   step = {data[W-1], data[W-1:1]};
        M_ROT:   step = {data[0], data[W-1:1]};
        default: step = {ser_in, data[W-1:1]};
      endcase
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    data_n  = data;
    carry_n = carry_q;
    dir_n   = dir_q;
    mode_n  = mode_q;
`ifdef SEQ_SHIFT_OVF_EN
    ovf_n   = ovf_q;
`endif
    case (state)
      IDLE: begin
        if (load) begin
          data_n = in;
        end else if (start) begin
          dir_n   = dir;
          mode_n  = mode;
          carry_n = 1'b0;
`ifdef SEQ_SHIFT_OVF_EN
          ovf_n   = 1'b0;
`endif
          if (amt == '0) begin
            state_n = DONE;
          end else begin
            cnt_n   = amt;
            state_n = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_n  = step;
        carry_n = step_out;
        cnt_n   = cnt - AMT_W'(1);
`ifdef SEQ_SHIFT_OVF_EN
        // Sign change on a left logical/arithmetic step means the value overflowed.
        if (!dir_q && !mode_q[1] && (step[W-1] != data[W-1]))
          ovf_n = 1'b1;
`endif
        if (cnt == AMT_W'(1))
          state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      data    <= '0;
      carry_q <= 1'b0;
      dir_q   <= 1'b0;
      mode_q  <= M_LOG;
`ifdef SEQ_SHIFT_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else if (en) begin
      state   <= state_n;
      cnt     <= cnt_n;
      data    <= data_n;
      carry_q <= carry_n;
      dir_q   <= dir_n;
      mode_q  <= mode_n;
`ifdef SEQ_SHIFT_OVF_EN
      ovf_q   <= ovf_n;
`endif
    end
  end

  assign o         = data;
  assign carry     = carry_q;
  assign busy      = (state == SHIFT);
  assign done      = (state == DONE);
  assign dbg_state = state;
`ifdef SEQ_SHIFT_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
